// File: rtl/mem_arb_pkg.sv
// Shared encodings for the instruction/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_I    = 2'd1,
    RESP_D    = 2'd2
  } resp_sel_e;

  localparam int STARVE_CNT_W = 8;

endpackage

// File: rtl/arb_starve_guard.sv
// Counts consecutive cycles the instruction side waits and forces it to win at the limit.
module arb_starve_guard
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_inst_req,
  input  logic i_inst_gnt,
  output logic o_force_inst
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

  logic [STARVE_CNT_W-1:0] r_starve_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (i_inst_req && !i_inst_gnt) begin
      if (r_starve_cnt != LIMIT) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end
    end else begin
      r_starve_cnt <= '0;
    end
  end

  assign o_force_inst = (r_starve_cnt == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read memory port between instruction fetch (I) and load/store (D),
// routing the 1-cycle-latency read data back to whichever side issued the read.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_request,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  resp_sel_e r_resp_sel;
  resp_sel_e w_resp_nxt;
  logic      w_force_i;
  logic      w_i_win;
  logic      w_d_win;
  logic      w_unused;

  // Byte-offset bits are dropped on the way to the word-addressed memory.
  assign w_unused = ^{i_addr[1:0], d_addr[1:0]};

  arb_starve_guard #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve_guard (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_inst_req  (i_req),
    .i_inst_gnt  (i_gnt),
    .o_force_inst(w_force_i)
  );

  always_comb begin
    w_i_win = 1'b0;
    w_d_win = 1'b0;
    if (d_req && !(i_req && w_force_i)) begin
      w_d_win = 1'b1;
    end else if (i_req) begin
      w_i_win = 1'b1;
    end
  end

  // Grants stay combinational but are held off while reset is asserted.
  assign i_gnt       = w_i_win & rst_n;
  assign d_gnt       = w_d_win & rst_n;
  assign mem_request = i_gnt | d_gnt;
  assign mem_we      = d_gnt & d_we;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_addr  = {2'b00, d_addr[ADDR_WIDTH-1:2]};
      mem_wdata = d_wdata;
    end else if (i_gnt) begin
      mem_addr  = {2'b00, i_addr[ADDR_WIDTH-1:2]};
    end
  end

  always_comb begin
    w_resp_nxt = RESP_NONE;
    if (i_gnt) begin
      w_resp_nxt = RESP_I;
    end else if (d_gnt && !d_we) begin
      w_resp_nxt = RESP_D;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_sel <= RESP_NONE;
    end else begin
      r_resp_sel <= w_resp_nxt;
    end
  end

  assign i_rvalid = (r_resp_sel == RESP_I);
  assign d_rvalid = (r_resp_sel == RESP_D);
  assign i_rdata  = i_rvalid ? mem_rdata : '0;
  assign d_rdata  = d_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed + randomized bench for mem_port_arbiter with a behavioural memory and reference model.
module tb_mem_port_arbiter;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_req, d_req, d_we;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic          i_gnt, i_rvalid, d_gnt, d_rvalid;
  logic [DW-1:0] i_rdata, d_rdata;
  logic          mem_request, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_request(mem_request), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] init_word(input int k);
    return (32'(k) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // Environment memory: 64 words, synchronous read, preloaded on the first edge.
  logic [DW-1:0] mem [64];
  logic          mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int k = 0; k < 64; k++) mem[k] <= init_word(k);
      mem_loaded <= 1'b1;
    end else if (mem_request) begin
      if (mem_we) mem[mem_addr[5:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[5:0]];
    end
  end

  // Reference model state
  logic [DW-1:0] ref_mem [64];
  int            loss;
  int            exp_kind;   // 0 none, 1 I read returning, 2 D read returning
  logic [DW-1:0] exp_data;
  int            n_cmp = 0;
  int            n_err = 0;
  logic          last_i_gnt, last_d_gnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at posedge+1, check at negedge, advance the model, return to posedge+1.
  task automatic step(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                      input logic [31:0] da, input logic [31:0] dwd);
    int win;
    i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd;
    @(negedge clk);
    if (ir && dr)  win = (loss == LIM) ? 1 : 2;
    else if (dr)   win = 2;
    else if (ir)   win = 1;
    else           win = 0;
    chk("i_gnt", i_gnt, win == 1);
    chk("d_gnt", d_gnt, win == 2);
    chk("mem_request", mem_request, win != 0);
    chk("mem_we", mem_we, (win == 2) && dw);
    chk("mem_addr", mem_addr, (win == 2) ? {2'b00, da[31:2]} :
                              (win == 1) ? {2'b00, ia[31:2]} : 32'h0);
    chk("mem_wdata", mem_wdata, (win == 2) ? dwd : 32'h0);
    chk("i_rvalid", i_rvalid, exp_kind == 1);
    chk("d_rvalid", d_rvalid, exp_kind == 2);
    chk("i_rdata", i_rdata, (exp_kind == 1) ? exp_data : 32'h0);
    chk("d_rdata", d_rdata, (exp_kind == 2) ? exp_data : 32'h0);
    last_i_gnt = i_gnt;
    last_d_gnt = d_gnt;
    if (ir && win != 1) loss = (loss < LIM) ? loss + 1 : LIM;
    else                loss = 0;
    exp_kind = 0;
    if (win == 1) begin
      exp_kind = 1;
      exp_data = ref_mem[ia[7:2]];
    end else if (win == 2) begin
      if (dw) ref_mem[da[7:2]] = dwd;
      else begin
        exp_kind = 2;
        exp_data = ref_mem[da[7:2]];
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; leaves requests idle and returns at posedge+1.
  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    chk("rst_i_rvalid", i_rvalid, 1'b0);
    chk("rst_d_rvalid", d_rvalid, 1'b0);
    chk("rst_i_rdata", i_rdata, 32'h0);
    chk("rst_i_gnt_masked", i_gnt, 1'b0);
    chk("rst_d_gnt_masked", d_gnt, 1'b0);
    chk("rst_mem_request", mem_request, 1'b0);
    i_req = 1'b0; d_req = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    loss = 0;
    exp_kind = 0;
    @(posedge clk);
    #1;
  endtask

  logic          pi, pd, pdw;
  logic [31:0]   pia, pda, pdwd;
  int            iwins;

  initial begin
    for (int k = 0; k < 64; k++) ref_mem[k] = init_word(k);
    loss = 0; exp_kind = 0; exp_data = '0;
    rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    #3;
    chk("reset_i_rvalid", i_rvalid, 1'b0);
    chk("reset_d_rvalid", d_rvalid, 1'b0);
    chk("reset_mem_request", mem_request, 1'b0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Instruction fetch only, then its read return
    step(1, 32'h10, 0, 0, 32'h0, 32'h0);
    chk("ifetch_rdata", i_rdata, init_word(4));
    step(0, 32'h0, 0, 0, 32'h0, 32'h0);

    // Store then load of the same word
    step(0, 32'h0, 1, 1, 32'h8, 32'hCAFE_F00D);
    step(0, 32'h0, 1, 0, 32'h8, 32'h0);
    chk("load_after_store", d_rdata, 32'hCAFE_F00D);
    step(0, 32'h0, 0, 0, 32'h0, 32'h0);

    // Both sides held: D wins LIM times, then I is forced once
    iwins = 0;
    for (int k = 0; k < 10; k++) begin
      step(1, 32'h20, 1, 0, 32'h34, 32'h0);
      if (last_i_gnt) iwins++;
    end
    chk("starve_i_wins", iwins, 2);
    step(0, 32'h0, 0, 0, 32'h0, 32'h0);

    // Alternating I/D with unaligned low bits
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) step(1, 32'h40 + 32'(k * 4) + 32'd3, 0, 0, 32'h0, 32'h0);
      else            step(0, 32'h0, 1, 0, 32'h80 + 32'(k * 4) + 32'd1, 32'h0);
    end

    // Reset in the cycle after an I read grant
    step(1, 32'hC4, 0, 0, 32'h0, 32'h0);
    chk("pre_rst_i_rvalid", i_rvalid, 1'b1);
    reset_pulse();

    // Reset mid-starvation must clear the wait count
    for (int k = 0; k < 3; k++) step(1, 32'h28, 1, 0, 32'h2C, 32'h0);
    reset_pulse();
    for (int k = 0; k < 6; k++) step(1, 32'h28, 1, 0, 32'h2C, 32'h0);

    // Idle with garbage addresses
    for (int k = 0; k < 10; k++) step(0, $urandom, 0, $urandom_range(0, 1), $urandom, $urandom);

    // Random traffic with hold-until-grant requesters
    pi = 0; pd = 0; pdw = 0; pia = '0; pda = '0; pdwd = '0;
    for (int k = 0; k < 400; k++) begin
      if (!pi) begin
        pi  = ($urandom_range(0, 99) < 60);
        pia = $urandom;
      end else if ($urandom_range(0, 9) == 0) pi = 0;
      if (!pd) begin
        pd   = ($urandom_range(0, 99) < 60);
        pdw  = ($urandom_range(0, 2) == 0);
        pda  = $urandom;
        pdwd = $urandom;
      end else if ($urandom_range(0, 9) == 0) pd = 0;
      step(pi, pia, pd, pdw, pda, pdwd);
      if (last_i_gnt) pi = 0;
      if (last_d_gnt) pd = 0;
    end
    step(0, 32'h0, 0, 0, 32'h0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
